// File: rtl/serial_reduce_sum.sv
// Sequential popcount accumulator: s = a + popcount(b), consuming LANES bits of b per clock.
// Valid/ready on both sides; wrap or saturate on overflow with a sticky overflow flag.
module serial_reduce_sum #(
  parameter int A_SIZE   = 8,
  parameter int B_SIZE   = 8,
  parameter int LANES    = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [A_SIZE-1:0] a,
  input  logic [B_SIZE-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [A_SIZE-1:0] s,
  output logic              ovf,
  output logic              busy
);

  localparam int BEATS = B_SIZE / LANES;
  localparam int PC_W  = $clog2(LANES + 1);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  generate
    if ((LANES < 1) || (B_SIZE % LANES != 0)) begin : g_bad_lanes
      $error("serial_reduce_sum: B_SIZE must be a positive multiple of LANES");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [A_SIZE-1:0] acc_reg, acc_next;
  logic [B_SIZE-1:0] shreg_reg, shreg_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              ovf_int_reg, ovf_int_next;
  logic [A_SIZE-1:0] s_reg, s_next;
  logic              ovf_reg, ovf_next;

  logic [PC_W-1:0]   lane_pop;
  logic [A_SIZE:0]   sum_wide;
  logic              carry;
  logic [A_SIZE-1:0] acc_step;
  logic              last_beat;

  // Popcount of the lanes currently at the bottom of the shift register
  always_comb begin
    lane_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_pop = lane_pop + PC_W'(shreg_reg[i]);
    end
  end

  assign sum_wide  = {1'b0, acc_reg} + (A_SIZE + 1)'(lane_pop);
  assign carry     = sum_wide[A_SIZE];
  assign last_beat = (cnt_reg == LAST_BEAT);

  // Once saturated, the accumulator is pinned at all-ones for the rest of the op
  always_comb begin
    acc_step = sum_wide[A_SIZE-1:0];
    if (SATURATE && (carry || ovf_int_reg)) begin
      acc_step = '1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_beat) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    busy      = (state_reg != IDLE);
  end

  assign s   = s_reg;
  assign ovf = ovf_reg;

  // Datapath next values; result registers move only on the final RUN beat
  always_comb begin
    acc_next     = acc_reg;
    shreg_next   = shreg_reg;
    cnt_next     = cnt_reg;
    ovf_int_next = ovf_int_reg;
    s_next       = s_reg;
    ovf_next     = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          acc_next     = a;
          shreg_next   = b;
          cnt_next     = '0;
          ovf_int_next = 1'b0;
        end
      end
      RUN: begin
        acc_next     = acc_step;
        ovf_int_next = ovf_int_reg | carry;
        shreg_next   = shreg_reg >> LANES;
        cnt_next     = cnt_reg + CNT_W'(1);
        if (last_beat) begin
          s_next   = acc_step;
          ovf_next = ovf_int_reg | carry;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg     <= '0;
      shreg_reg   <= '0;
      cnt_reg     <= '0;
      ovf_int_reg <= 1'b0;
      s_reg       <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      acc_reg     <= acc_next;
      shreg_reg   <= shreg_next;
      cnt_reg     <= cnt_next;
      ovf_int_reg <= ovf_int_next;
      s_reg       <= s_next;
      ovf_reg     <= ovf_next;
    end
  end

endmodule

// File: tb/tb_serial_reduce_sum.sv
// Bench for serial_reduce_sum: table vectors on wrap/saturate/single-beat instances,
// backpressure and async-reset sequences, and a randomized run against an arithmetic model.
module tb_serial_reduce_sum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, ovf, busy;
  logic [7:0] a = '0, b = '0, s;

  logic       in_valid2 = 1'b0, out_ready2 = 1'b1;
  logic [7:0] a2 = '0, b2 = '0;
  logic       in_ready_s, out_valid_s, ovf_s, busy_s;
  logic [7:0] s_s;
  logic       in_ready_8, out_valid_8, ovf_8, busy_8;
  logic [7:0] s_8;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  serial_reduce_sum #(.A_SIZE(8), .B_SIZE(8), .LANES(2), .SATURATE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .ovf(ovf), .busy(busy)
  );

  serial_reduce_sum #(.A_SIZE(8), .B_SIZE(8), .LANES(2), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready_s), .a(a2), .b(b2),
    .out_valid(out_valid_s), .out_ready(out_ready2), .s(s_s), .ovf(ovf_s), .busy(busy_s)
  );

  serial_reduce_sum #(.A_SIZE(8), .B_SIZE(8), .LANES(8), .SATURATE(1'b0)) dut_l8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready_8), .a(a2), .b(b2),
    .out_valid(out_valid_8), .out_ready(out_ready2), .s(s_8), .ovf(ovf_8), .busy(busy_8)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s_wrap;
    logic       ovf;
    logic [7:0] s_sat;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference: true sum in plain integer arithmetic, then wrap or clamp
  function automatic logic [8:0] ref_sum(input logic [7:0] av, input logic [7:0] bv, input bit sat);
    int t;
    t = int'(av) + $countones(bv);
    if (t > 255) return {1'b1, sat ? 8'hFF : 8'(t - 256)};
    return {1'b0, 8'(t)};
  endfunction

  task automatic run_main(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] exp_s, input logic exp_ovf);
    int k;
    int lat;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready) begin
      timeout_fail("main_in_ready");
      return;
    end
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      timeout_fail("main_out_valid");
      return;
    end
    check("main_latency", lat, 4);
    check("main_s", s, exp_s);
    check("main_ovf", ovf, exp_ovf);
    $display("main op a=%02h b=%02h -> s=%02h ovf=%0b latency=%0d", av, bv, s, ovf, lat);
    if (out_ready) begin
      @(posedge clk); #1;
      check("main_post_out_valid", out_valid, 0);
      check("main_post_in_ready", in_ready, 1);
    end
  endtask

  task automatic run_pair(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] exp_wrap,
                          input logic exp_ovf, input logic [7:0] exp_sat);
    int k;
    int lat;
    int lat_s;
    int lat_8;
    logic [7:0] ss, s8;
    logic os, o8;
    bit got_s, got_8;
    k = 0;
    while (!(in_ready_s && in_ready_8) && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (!(in_ready_s && in_ready_8)) begin
      timeout_fail("pair_in_ready");
      return;
    end
    a2 = av; b2 = bv; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = 0; got_s = 0; got_8 = 0; lat_s = 0; lat_8 = 0;
    ss = '0; s8 = '0; os = 0; o8 = 0;
    while (!(got_s && got_8) && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (out_valid_s && !got_s) begin
        got_s = 1; lat_s = lat; ss = s_s; os = ovf_s;
      end
      if (out_valid_8 && !got_8) begin
        got_8 = 1; lat_8 = lat; s8 = s_8; o8 = ovf_8;
      end
    end
    if (!(got_s && got_8)) begin
      timeout_fail("pair_out_valid");
      return;
    end
    check("sat_latency", lat_s, 4);
    check("sat_s", ss, exp_sat);
    check("sat_ovf", os, exp_ovf);
    check("l8_latency", lat_8, 1);
    check("l8_s", s8, exp_wrap);
    check("l8_ovf", o8, exp_ovf);
    $display("pair op a=%02h b=%02h -> sat s=%02h ovf=%0b, lanes8 s=%02h ovf=%0b", av, bv, ss, os, s8, o8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h05, 8'hFF, 8'h0D, 1'b0, 8'h0D};
    tbl[1] = '{8'hFC, 8'h0F, 8'h00, 1'b1, 8'hFF};
    tbl[2] = '{8'h3A, 8'h00, 8'h3A, 1'b0, 8'h3A};
    tbl[3] = '{8'hFF, 8'h01, 8'h00, 1'b1, 8'hFF};
    tbl[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 8'hFF};
    tbl[5] = '{8'hF9, 8'hAA, 8'hFD, 1'b0, 8'hFD};
    tbl[6] = '{8'hFA, 8'hFF, 8'h02, 1'b1, 8'hFF};
    tbl[7] = '{8'h00, 8'h80, 8'h01, 1'b0, 8'h01};

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_main(tbl[i].a, tbl[i].b, tbl[i].s_wrap, tbl[i].ovf);
      run_pair(tbl[i].a, tbl[i].b, tbl[i].s_wrap, tbl[i].ovf, tbl[i].s_sat);
    end

    // Backpressure: hold DONE for 5 cycles
    out_ready = 1'b0;
    run_main(8'hFF, 8'h03, 8'h01, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_s", s, 8'h01);
      check("bp_ovf", ovf, 1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    check("bp_release_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("bp_after_out_valid", out_valid, 0);
    check("bp_after_in_ready", in_ready, 1);
    check("bp_after_busy", busy, 0);
    $display("backpressure op released after 5 stalled cycles");

    // Asynchronous reset in the second RUN cycle
    a = 8'h05; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_s", s, 0);
    check("arst_ovf", ovf, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("arst_no_pulse", seen, 0);
    end
    $display("async reset op discarded");
    run_main(8'h01, 8'h81, 8'h03, 1'b0);

    // Randomized: in_valid held high, random out_ready, scoreboard queue
    begin
      logic [8:0] exp_q[$];
      logic [8:0] e;
      int n_acc;
      int n_res;
      int cyc;
      int last_acc;
      n_acc = 0; n_res = 0; cyc = 0; last_acc = 0;
      while (n_res < 200 && cyc < 20000) begin
        out_ready = 1'($urandom_range(0, 1));
        in_valid = (n_acc < 200);
        if (in_valid && in_ready) begin
          a = 8'($urandom);
          b = 8'($urandom);
          exp_q.push_back(ref_sum(a, b, 1'b0));
          if (n_acc > 0) check("rand_spacing", (cyc - last_acc) >= 6, 1);
          last_acc = cyc;
          n_acc++;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("rand_unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rand_s", s, e[7:0]);
            check("rand_ovf", ovf, e[8]);
            $display("rand result %0d: s=%02h ovf=%0b expected s=%02h ovf=%0b", n_res, s, ovf, e[7:0], e[8]);
          end
          n_res++;
        end
        @(posedge clk); #1;
        cyc++;
      end
      in_valid = 1'b0;
      if (n_res < 200) timeout_fail("rand_results");
      check("rand_queue_empty", exp_q.size(), 0);
      check("rand_accepted", n_acc, 200);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
